// File: rtl/io_pwm_pkg.sv
// Shared constants for io_pwm: register map, CTRL bit positions, counter width and reset values.
// Also holds the address-window helpers used by both the write decode and the read chain.
package io_pwm_pkg;

  localparam int CW = 16;

  localparam logic [2:0] OFS_CTRL   = 3'd0;
  localparam logic [2:0] OFS_PERIOD = 3'd1;
  localparam logic [2:0] OFS_DUTY0  = 3'd2;
  localparam logic [2:0] OFS_DUTY1  = 3'd3;
  localparam logic [2:0] OFS_DUTY2  = 3'd4;
  localparam logic [2:0] OFS_STATUS = 3'd5;
  localparam int         NUM_REGS   = 6;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_INV       = 3;
  localparam int CTRL_IRQ_EN    = 4;
  localparam int CTRL_PRESC_LSB = 8;

  localparam logic [CW-1:0] PERIOD_RST = 16'hFFFF;

  // Wrapping subtraction: addresses below the base land far above NUM_REGS.
  function automatic logic reg_hit(input logic [13:0] adr, input logic [13:0] base);
    logic [13:0] d;
    d = adr - base;
    return d < 14'(NUM_REGS);
  endfunction

  function automatic logic [2:0] reg_ofs(input logic [13:0] adr, input logic [13:0] base);
    logic [13:0] d;
    d = adr - base;
    return d[2:0];
  endfunction

endpackage

// File: rtl/io_pwm_channel.sv
// One PWM channel: duty shadow, compare against the shared counter, registered output.
// Latency: 1 cycle from counter value to pin. Backpressure: none (free-running output).
module io_pwm_channel
  import io_pwm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          inv,
  input  logic          wrap,
  input  logic [CW-1:0] duty,
  input  logic [CW-1:0] cnt,
  output logic          pwm
);

  logic [CW-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      pwm    <= 1'b0;
    end else begin
      // Duty changes become visible only at a period boundary while running.
      if (!en || wrap) shadow <= duty;
      pwm <= inv ^ (en && (cnt < shadow));
    end
  end

endmodule

// File: rtl/io_pwm.sv
// Three-channel PWM on the dma_io bus, chained into the read-data daisy chain; raises a wrap pulse.
// Latency: register writes 1 cycle, reads combinational, pins 1 cycle. Backpressure: none, bus always accepted.
module io_pwm
  import io_pwm_pkg::*;
#(
  parameter logic [13:0] BASE_ADR = 14'h0E00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic [2:0]  pwm_out,
  output logic        pwm_wrap_1shot
);

  logic          en, inv, irq_en;
  logic [7:0]    presc, pcnt;
  logic [CW-1:0] period, cnt;
  logic [CW-1:0] duty [3];
  logic          wrap_sticky;
  logic          tick, wrap, w_hit, r_hit;
  logic [2:0]    w_ofs, r_ofs;
  logic [31:0]   reg_rdata;

  assign w_hit = dma_io_we && reg_hit(dma_io_wadr, BASE_ADR);
  assign w_ofs = reg_ofs(dma_io_wadr, BASE_ADR);
  assign r_hit = dma_io_radr_en && reg_hit(dma_io_radr, BASE_ADR);
  assign r_ofs = reg_ofs(dma_io_radr, BASE_ADR);

  assign tick = en && (pcnt == presc);
  // >= so that lowering PERIOD below the running count wraps on the next tick.
  assign wrap = tick && (cnt >= period);

  always_ff @(posedge clk) begin
    if (rst) begin
      en             <= 1'b0;
      inv            <= 1'b0;
      irq_en         <= 1'b0;
      presc          <= '0;
      period         <= PERIOD_RST;
      for (int i = 0; i < 3; i++) duty[i] <= '0;
      wrap_sticky    <= 1'b0;
      pcnt           <= '0;
      cnt            <= '0;
      pwm_wrap_1shot <= 1'b0;
    end else begin
      if (w_hit) begin
        case (w_ofs)
          OFS_CTRL: begin
            en     <= dma_io_wdata[CTRL_EN];
            inv    <= dma_io_wdata[CTRL_INV];
            irq_en <= dma_io_wdata[CTRL_IRQ_EN];
            presc  <= dma_io_wdata[CTRL_PRESC_LSB +: 8];
          end
          OFS_PERIOD: period  <= dma_io_wdata[CW-1:0];
          OFS_DUTY0:  duty[0] <= dma_io_wdata[CW-1:0];
          OFS_DUTY1:  duty[1] <= dma_io_wdata[CW-1:0];
          OFS_DUTY2:  duty[2] <= dma_io_wdata[CW-1:0];
          default: ;
        endcase
      end

      // A wrap in the same cycle as a W1C keeps the flag set.
      if (wrap) wrap_sticky <= 1'b1;
      else if (w_hit && (w_ofs == OFS_STATUS) && dma_io_wdata[0]) wrap_sticky <= 1'b0;

      if (!en || tick) pcnt <= '0;
      else             pcnt <= pcnt + 8'd1;

      if (!en || wrap) cnt <= '0;
      else if (tick)   cnt <= cnt + CW'(1);

      pwm_wrap_1shot <= wrap && irq_en;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (r_ofs)
      OFS_CTRL:   reg_rdata = {16'h0, presc, 3'b000, irq_en, inv, 2'b00, en};
      OFS_PERIOD: reg_rdata = 32'(period);
      OFS_DUTY0:  reg_rdata = 32'(duty[0]);
      OFS_DUTY1:  reg_rdata = 32'(duty[1]);
      OFS_DUTY2:  reg_rdata = 32'(duty[2]);
      OFS_STATUS: reg_rdata = {cnt, 15'h0, wrap_sticky};
      default: ;
    endcase
  end

  assign dma_io_rdata = r_hit ? reg_rdata : dma_io_rdata_in;

  for (genvar n = 0; n < 3; n++) begin : g_ch
    io_pwm_channel u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .inv  (inv),
      .wrap (wrap),
      .duty (duty[n]),
      .cnt  (cnt),
      .pwm  (pwm_out[n])
    );
  end

endmodule

// File: tb/tb_io_pwm.sv
// Bench for io_pwm: register table, hand-written period/duty/reset sequences, randomized configs vs an analytic model.
module tb_io_pwm;

  localparam logic [13:0] BASE = 14'h0E00;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  logic [2:0]  pwm_out;
  logic        pwm_wrap_1shot;

  io_pwm #(.BASE_ADR(BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .dma_io_we      (dma_io_we),
    .dma_io_wadr    (dma_io_wadr),
    .dma_io_wdata   (dma_io_wdata),
    .dma_io_radr    (dma_io_radr),
    .dma_io_radr_en (dma_io_radr_en),
    .dma_io_rdata_in(dma_io_rdata_in),
    .dma_io_rdata   (dma_io_rdata),
    .pwm_out        (pwm_out),
    .pwm_wrap_1shot (pwm_wrap_1shot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] adr;
    logic        en;
    logic [31:0] exp;
  } rvec_t;

  rvec_t       tbl [9];
  int          checks = 0;
  int          errors = 0;
  int          p, n, len;
  int          du [3];
  bit          iv, ir, anyw;
  logic [2:0]  ep;
  logic [31:0] v, ctrlw;

  // With a static config enabled at cycle 0, each count value lasts presc+1 cycles.
  function automatic int cntf(input int s, input int ps, input int pd);
    return (s / (ps + 1)) % (pd + 1);
  endfunction

  function automatic bit wrapf(input int s, input int ps, input int pd);
    return ((s % (ps + 1)) == ps) && (cntf(s, ps, pd) == pd);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [13:0] adr, input logic [31:0] d);
    dma_io_we    = 1'b1;
    dma_io_wadr  = adr;
    dma_io_wdata = d;
    @(negedge clk);
    dma_io_we    = 1'b0;
  endtask

  task automatic rd(input logic [13:0] adr, output logic [31:0] val);
    dma_io_radr    = adr;
    dma_io_radr_en = 1'b1;
    #1;
    val            = dma_io_rdata;
    dma_io_radr_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{BASE + 14'd0, 1'b1, 32'h0000_0000};
    tbl[1] = '{BASE + 14'd1, 1'b1, 32'h0000_FFFF};
    tbl[2] = '{BASE + 14'd2, 1'b1, 32'h0000_0000};
    tbl[3] = '{BASE + 14'd3, 1'b1, 32'h0000_0000};
    tbl[4] = '{BASE + 14'd4, 1'b1, 32'h0000_0000};
    tbl[5] = '{BASE + 14'd5, 1'b1, 32'h0000_0000};
    tbl[6] = '{BASE + 14'd6, 1'b1, 32'hDEAD_BEEF};
    tbl[7] = '{BASE - 14'd1, 1'b1, 32'hDEAD_BEEF};
    tbl[8] = '{BASE + 14'd1, 1'b0, 32'hDEAD_BEEF};

    rst = 1'b1; dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
    dma_io_radr = '0; dma_io_radr_en = 1'b0; dma_io_rdata_in = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_wrap", 32'(pwm_wrap_1shot), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      dma_io_radr    = tbl[i].adr;
      dma_io_radr_en = tbl[i].en;
      #1;
      chk($sformatf("reg_tbl%0d", i), dma_io_rdata, tbl[i].exp);
      dma_io_radr_en = 1'b0;
      @(negedge clk);
    end
    wr(BASE + 14'd6, 32'h0);
    wr(BASE + 14'd7, 32'h0);
    rd(BASE + 14'd1, v); chk("ignored_wr_period", v, 32'h0000_FFFF);

    // PERIOD=4, DUTY0=2, IRQ_EN+EN: pattern 1,1,0,0,0 and a pulse every 5 cycles.
    wr(BASE + 14'd1, 32'd4); wr(BASE + 14'd2, 32'd2); wr(BASE + 14'd4, 32'd0);
    wr(BASE + 14'd0, 32'h11);
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      chk("a_pwm0", 32'(pwm_out[0]), 32'(((t - 1) % 5) < 2));
      chk("a_pwm2_duty0", 32'(pwm_out[2]), 32'h0);
      chk("a_wrap_pulse", 32'(pwm_wrap_1shot), 32'((t % 5) == 0));
    end
    rd(BASE + 14'd5, v); chk("a_status", v, 32'h0000_0001);

    // Mid-period DUTY0=4 / DUTY2=9: current period keeps old duty.
    @(negedge clk);
    wr(BASE + 14'd2, 32'd4); wr(BASE + 14'd4, 32'd9);
    chk("dchg_pwm0_t13", 32'(pwm_out[0]), 32'h0);
    for (int t = 14; t <= 20; t++) begin
      @(negedge clk);
      chk("dchg_pwm0", 32'(pwm_out[0]), 32'((t >= 16) && (t <= 19)));
      chk("dchg_pwm2", 32'(pwm_out[2]), 32'(t >= 16));
    end

    // PRESC=3, PERIOD=1, DUTY1=1: 4 high / 4 low.
    wr(BASE + 14'd0, 32'h0); wr(BASE + 14'd1, 32'd1); wr(BASE + 14'd3, 32'd1);
    wr(BASE + 14'd0, 32'h0301);
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      chk("presc_pwm1", 32'(pwm_out[1]), 32'((((t - 1) / 4) % 2) == 0));
      rd(BASE + 14'd5, v);
      chk("presc_cnt", 32'(v[31:16]), 32'((t / 4) % 2));
    end

    // INV with EN=0, then W1C racing a wrap.
    wr(BASE + 14'd0, 32'h08);
    @(negedge clk);
    chk("inv_dis_pwm", 32'(pwm_out), 32'h7);
    wr(BASE + 14'd1, 32'd0); wr(BASE + 14'd0, 32'h01);
    wr(BASE + 14'd5, 32'h1);
    rd(BASE + 14'd5, v); chk("w1c_vs_wrap", v, 32'h0000_0001);
    wr(BASE + 14'd0, 32'h0); wr(BASE + 14'd5, 32'h1);
    rd(BASE + 14'd5, v); chk("w1c_clear", v, 32'h0);

    // Lowering PERIOD below the running count wraps on the next tick.
    wr(BASE + 14'd1, 32'd9); wr(BASE + 14'd0, 32'h01);
    repeat (5) @(negedge clk);
    wr(BASE + 14'd1, 32'd2);
    rd(BASE + 14'd5, v); chk("lower_period_cnt6", v, 32'h0006_0000);
    @(negedge clk);
    rd(BASE + 14'd5, v); chk("lower_period_wrap", v, 32'h0000_0001);

    // Reset mid-period at cnt=3.
    wr(BASE + 14'd0, 32'h0); wr(BASE + 14'd1, 32'd9); wr(BASE + 14'd0, 32'h11);
    repeat (3) @(negedge clk);
    rd(BASE + 14'd5, v); chk("pre_rst_cnt", 32'(v[31:16]), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm", 32'(pwm_out), 32'h0);
    chk("mid_rst_wrap", 32'(pwm_wrap_1shot), 32'h0);
    rd(BASE + 14'd5, v); chk("mid_rst_status", v, 32'h0);
    rd(BASE + 14'd1, v); chk("mid_rst_period", v, 32'h0000_FFFF);
    rst = 1'b0;
    @(negedge clk);

    // Randomized static configurations against the closed-form model.
    for (int it = 0; it < 20; it++) begin
      p   = int'($urandom_range(0, 3));
      n   = int'($urandom_range(0, 7));
      len = 48;
      for (int k = 0; k < 3; k++) du[k] = int'($urandom_range(0, n + 2));
      iv  = 1'($urandom_range(0, 1));
      ir  = 1'($urandom_range(0, 1));
      wr(BASE + 14'd0, 32'h0); wr(BASE + 14'd5, 32'h1);
      wr(BASE + 14'd1, 32'(n));
      wr(BASE + 14'd2, 32'(du[0])); wr(BASE + 14'd3, 32'(du[1])); wr(BASE + 14'd4, 32'(du[2]));
      ctrlw = 32'h1 | (32'(iv) << 3) | (32'(ir) << 4) | (32'(p) << 8);
      wr(BASE + 14'd0, ctrlw);
      chk("rnd_pwm_t0", 32'(pwm_out), 32'h0);
      anyw = 1'b0;
      for (int t = 1; t <= len; t++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) ep[k] = iv ^ (cntf(t - 1, p, n) < du[k]);
        chk("rnd_pwm", 32'(pwm_out), 32'(ep));
        chk("rnd_wrap", 32'(pwm_wrap_1shot), 32'(ir && wrapf(t - 1, p, n)));
        anyw = anyw | wrapf(t - 1, p, n);
      end
      rd(BASE + 14'd5, v);
      chk("rnd_status", v, {16'(cntf(len, p, n)), 15'h0, anyw});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
